axi4_lite_register_arbiter: RTL and testbench

AXI4_LITE_REGISTER_ARBITER -- requirements
Module: axi4_lite_register_arbiter

---
 rtl/axi4_lite_register_arbiter_if.sv | 70 +++++++
 rtl/axi4_lite_register_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_axi4_lite_register_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_register_arbiter_if.sv
// ----------------------------------------------------------------------------
// axi4_if : AXI4-Lite channel bundle (AW, W, B, AR, R).
//
// Parameters
//   A : address width in bits
//   N : data bus width in bytes (data is 8*N bits, strobe is N bits)
//   I : ID width
//
// Modports
//   master : drives AW/W/AR payload and valids, B/R readies
//   slave  : drives AW/W/AR readies, B/R payload and valids
// ----------------------------------------------------------------------------
interface axi4_if #(
    parameter int A = 32,
    parameter int N = 4,
    parameter int I = 1
);
    // Write address channel
    logic             awvalid;
    logic             awready;
    logic [A-1:0]     awaddr;
    logic [2:0]       awprot;
    logic [I-1:0]     awid;
    // Write data channel
    logic             wvalid;
    logic             wready;
    logic [8*N-1:0]   wdata;
    logic [N-1:0]     wstrb;
    // Write response channel
    logic             bvalid;
    logic             bready;
    logic [1:0]       bresp;
    // Read address channel
    logic             arvalid;
    logic             arready;
    logic [A-1:0]     araddr;
    logic [2:0]       arprot;
    logic [I-1:0]     arid;
    // Read data channel
    logic             rvalid;
    logic             rready;
    logic [8*N-1:0]   rdata;
    logic [1:0]       rresp;

    modport master (
        output awvalid, awaddr, awprot, awid,
        input  awready,
        output wvalid, wdata, wstrb,
        input  wready,
        input  bvalid, bresp,
        output bready,
        output arvalid, araddr, arprot, arid,
        input  arready,
        input  rvalid, rdata, rresp,
        output rready
    );

    modport slave (
        input  awvalid, awaddr, awprot, awid,
        output awready,
        input  wvalid, wdata, wstrb,
        output wready,
        output bvalid, bresp,
        input  bready,
        input  arvalid, araddr, arprot, arid,
        output arready,
        output rvalid, rdata, rresp,
        input  rready
    );
endinterface

// File: rtl/axi4_lite_register_arbiter.sv
// ----------------------------------------------------------------------------
// axi4_lite_register_arbiter
//
// Round-robin arbiter that lets R simple requesters share one AXI4-Lite
// master port. One transaction is in flight at a time; each requester gets a
// single-cycle ack pulse when its access has completed on the bus.
//
// Parameters
//   A : AXI address width (>= 32)
//   N : data bus width in bytes (4 or 8)
//   I : AXI ID width (IDs are always driven 0)
//   R : number of requesters (2..8)
//
// Ports
//   aclk, aresetn : clock (rising edge) and asynchronous active-low reset
//   req[R]        : per-requester request, held until ack
//   we[R]         : per-requester direction, 1 = write, 0 = read
//   addr[R][A]    : per-requester byte address
//   wdata[R][8N]  : per-requester write data
//   ack[R]        : one-cycle completion pulse for the granted requester
//   rdata[8N]     : shared read data, valid with ack, held until next ack
//   resp[2]       : shared BRESP/RRESP, valid with ack, held until next ack
//   axi4_m        : AXI4-Lite master port
// ----------------------------------------------------------------------------
module axi4_lite_register_arbiter #(
    parameter int A = 32,
    parameter int N = 4,
    parameter int I = 1,
    parameter int R = 2
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [R-1:0]            req,
    input  logic [R-1:0]            we,
    input  logic [R-1:0][A-1:0]     addr,
    input  logic [R-1:0][8*N-1:0]   wdata,
    output logic [R-1:0]            ack,
    output logic [8*N-1:0]          rdata,
    output logic [1:0]              resp,
    axi4_if.master                  axi4_m
);

    localparam int GW = (R > 1) ? $clog2(R) : 1;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   last_q, last_d;
    logic [GW-1:0]   gnt_q, gnt_d;
    logic            aw_done_q, aw_done_d;
    logic            w_done_q, w_done_d;
    logic [8*N-1:0]  rdata_q, rdata_d;
    logic [1:0]      resp_q, resp_d;
    logic [A-1:0]    addr_q;
    logic [8*N-1:0]  wdata_q;

    logic            grant_vld;
    logic [GW-1:0]   grant_idx;

    // Round-robin pick: the first requester found walking upward from the
    // one after the previous winner, wrapping at R.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = 1; k <= R; k++) begin
            int idx;
            idx = (int'(last_q) + k) % R;
            if (!grant_vld && req[idx]) begin
                grant_vld = 1'b1;
                grant_idx = idx[GW-1:0];
            end
        end
    end

    // Next-state and captured-result logic
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        gnt_d     = gnt_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;

        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    gnt_d     = grant_idx;
                    last_d    = grant_idx;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = we[grant_idx] ? WR : RD_ADDR;
                end
            end
            WR: begin
                // AW and W complete independently; leave once both have.
                if (axi4_m.awvalid && axi4_m.awready) aw_done_d = 1'b1;
                if (axi4_m.wvalid && axi4_m.wready)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d)            state_d   = WR_RESP;
            end
            WR_RESP: begin
                if (axi4_m.bvalid) begin
                    resp_d  = axi4_m.bresp;
                    state_d = DONE;
                end
            end
            RD_ADDR: begin
                if (axi4_m.arready) state_d = RD_DATA;
            end
            RD_DATA: begin
                if (axi4_m.rvalid) begin
                    rdata_d = axi4_m.rdata;
                    resp_d  = axi4_m.rresp;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            last_q    <= GW'(R - 1);
            gnt_q     <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            gnt_q     <= gnt_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
        end
    end

    // Request payload is latched at grant so the bus sees a stable copy even
    // if the requester misbehaves after arbitration.
    always_ff @(posedge aclk) begin
        if (state_q == IDLE && grant_vld) begin
            addr_q  <= addr[grant_idx];
            wdata_q <= wdata[grant_idx];
        end
    end

    // AXI master drive; valids/readies come straight from the state so they
    // are low in reset and in IDLE.
    assign axi4_m.awvalid = (state_q == WR) && !aw_done_q;
    assign axi4_m.awaddr  = addr_q;
    assign axi4_m.awprot  = 3'b000;
    assign axi4_m.awid    = '0;
    assign axi4_m.wvalid  = (state_q == WR) && !w_done_q;
    assign axi4_m.wdata   = wdata_q;
    assign axi4_m.wstrb   = '1;
    assign axi4_m.bready  = (state_q == WR_RESP);
    assign axi4_m.arvalid = (state_q == RD_ADDR);
    assign axi4_m.araddr  = addr_q;
    assign axi4_m.arprot  = 3'b000;
    assign axi4_m.arid    = '0;
    assign axi4_m.rready  = (state_q == RD_DATA);

    always_comb begin
        ack = '0;
        if (state_q == DONE) ack[gnt_q] = 1'b1;
    end

    assign rdata = rdata_q;
    assign resp  = resp_q;

endmodule

// File: tb/tb_axi4_lite_register_arbiter.sv
// ----------------------------------------------------------------------------
// Directed bench for axi4_lite_register_arbiter (R=2, 32-bit bus) with a small
// AXI4-Lite register-file slave whose ready/response delays are adjustable.
// ----------------------------------------------------------------------------
module tb_axi4_lite_register_arbiter;

    localparam int A = 32;
    localparam int N = 4;
    localparam int I = 1;
    localparam int R = 2;

    logic                   aclk;
    logic                   aresetn;
    logic [R-1:0]           req;
    logic [R-1:0]           we;
    logic [R-1:0][A-1:0]    t_addr;
    logic [R-1:0][8*N-1:0]  t_wdata;
    logic [R-1:0]           ack;
    logic [8*N-1:0]         rdata;
    logic [1:0]             resp;

    int n_checks = 0;
    int n_errors = 0;

    axi4_if #(.A(A), .N(N), .I(I)) bus ();

    axi4_lite_register_arbiter #(.A(A), .N(N), .I(I), .R(R)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .req     (req),
        .we      (we),
        .addr    (t_addr),
        .wdata   (t_wdata),
        .ack     (ack),
        .rdata   (rdata),
        .resp    (resp),
        .axi4_m  (bus)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // ---------------- slave model ----------------
    logic [31:0] mem [0:15];
    int          aw_dly, w_dly, ar_dly, b_dly, r_dly;
    logic [1:0]  rresp_cfg;
    int          aw_cnt, w_cnt, ar_cnt, b_wait, r_wait, w_beats;
    logic        have_aw, have_w, b_pend, r_pend;
    logic [31:0] aw_a, w_d, r_d;
    logic        aw_hs, w_hs, ar_hs;
    logic [31:0] wr_addr, wr_data;

    assign aw_hs   = bus.awvalid && bus.awready;
    assign w_hs    = bus.wvalid && bus.wready;
    assign ar_hs   = bus.arvalid && bus.arready;
    assign wr_addr = have_aw ? aw_a : bus.awaddr;
    assign wr_data = have_w ? w_d : bus.wdata;

    assign bus.awready = (aw_cnt >= aw_dly);
    assign bus.wready  = (w_cnt >= w_dly);
    assign bus.arready = (ar_cnt >= ar_dly);
    assign bus.bvalid  = b_pend && (b_wait == 0);
    assign bus.bresp   = 2'b00;
    assign bus.rvalid  = r_pend && (r_wait == 0);
    assign bus.rdata   = r_d;
    assign bus.rresp   = rresp_cfg;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_cnt  <= 0;
            w_cnt   <= 0;
            ar_cnt  <= 0;
            b_wait  <= 0;
            r_wait  <= 0;
            w_beats <= 0;
            have_aw <= 1'b0;
            have_w  <= 1'b0;
            b_pend  <= 1'b0;
            r_pend  <= 1'b0;
            aw_a    <= '0;
            w_d     <= '0;
            r_d     <= '0;
            for (int i = 0; i < 16; i++) mem[i] <= 32'h1111_1111 * 32'(i);
        end else begin
            if (aw_hs) begin
                aw_cnt  <= 0;
                have_aw <= 1'b1;
                aw_a    <= bus.awaddr;
            end else if (bus.awvalid) begin
                aw_cnt <= aw_cnt + 1;
            end
            if (w_hs) begin
                w_cnt   <= 0;
                w_beats <= w_beats + 1;
                have_w  <= 1'b1;
                w_d     <= bus.wdata;
            end else if (bus.wvalid) begin
                w_cnt <= w_cnt + 1;
            end
            if ((have_aw || aw_hs) && (have_w || w_hs) && !b_pend) begin
                mem[wr_addr[5:2]] <= wr_data;
                have_aw <= 1'b0;
                have_w  <= 1'b0;
                b_pend  <= 1'b1;
                b_wait  <= b_dly;
            end
            if (b_pend && b_wait != 0) b_wait <= b_wait - 1;
            if (bus.bvalid && bus.bready) b_pend <= 1'b0;
            if (ar_hs) begin
                ar_cnt <= 0;
                r_pend <= 1'b1;
                r_wait <= r_dly;
                r_d    <= mem[bus.araddr[5:2]];
            end else if (bus.arvalid) begin
                ar_cnt <= ar_cnt + 1;
            end
            if (r_pend && r_wait != 0) r_wait <= r_wait - 1;
            if (bus.rvalid && bus.rready) r_pend <= 1'b0;
        end
    end

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge aclk);
    endtask

    task automatic wait_ack(input int limit);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge aclk);
            if (ack != '0) ok = 1'b1;
        end
        if (!ok) check_val("ack_timeout", 64'd0, 64'd1);
    endtask

    function automatic logic [4:0] valids();
        return {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int beats0;
        aresetn   = 1'b0;
        req       = '0;
        we        = '0;
        t_addr    = '0;
        t_wdata   = '0;
        aw_dly    = 0;
        w_dly     = 0;
        ar_dly    = 0;
        b_dly     = 0;
        r_dly     = 0;
        rresp_cfg = 2'b00;

        // Reset state
        repeat (3) cyc();
        check_val("rst_valids", valids(), 5'b0);
        check_val("rst_ack",    ack,      2'b00);
        check_val("rst_rdata",  rdata,    32'h0);
        check_val("rst_resp",   resp,     2'b00);
        aresetn = 1'b1;

        // Idle with no request: nothing on the bus
        repeat (3) begin
            cyc();
            check_val("idle_valids", valids(), 5'b0);
        end

        // Zero-wait write, requester 0: 0xA5A5A5A5 -> 0x4
        t_addr[0]  = 32'h4;
        t_wdata[0] = 32'hA5A5_A5A5;
        we         = 2'b01;
        req        = 2'b01;
        cyc();  // cycle 1
        check_val("wr_c1_awv_wv", {bus.awvalid, bus.wvalid}, 2'b11);
        check_val("wr_c1_awaddr", bus.awaddr, 32'h4);
        check_val("wr_c1_wdata",  bus.wdata,  32'hA5A5_A5A5);
        check_val("wr_c1_wstrb",  bus.wstrb,  4'hF);
        check_val("wr_c1_prot_id", {bus.awprot, bus.awid}, 4'h0);
        cyc();  // cycle 2
        check_val("wr_c2_valids", valids(), 5'b00010);
        check_val("wr_c2_ack",    ack,      2'b00);
        cyc();  // cycle 3
        check_val("wr_c3_ack",    ack,      2'b01);
        check_val("wr_c3_resp",   resp,     2'b00);
        req = '0;
        check_val("wr_mem1",      mem[1],   32'hA5A5_A5A5);
        cyc();  // cycle 4
        check_val("wr_c4_ack",    ack,      2'b00);
        check_val("wr_c4_valids", valids(), 5'b0);

        // Zero-wait read back of 0x4
        we  = 2'b00;
        req = 2'b01;
        cyc();
        check_val("rd_c1_valids", valids(),   5'b00100);
        check_val("rd_c1_araddr", bus.araddr, 32'h4);
        cyc();
        check_val("rd_c2_valids", valids(),   5'b00001);
        cyc();
        check_val("rd_c3_ack",    ack,        2'b01);
        check_val("rd_c3_rdata",  rdata,      32'hA5A5_A5A5);
        check_val("rd_c3_resp",   resp,       2'b00);
        req = '0;
        cyc();

        // Round-robin after reset: both requesting reads, grants 0,1,0,1
        aresetn = 1'b0;
        cyc();
        check_val("rst2_rdata", rdata, 32'h0);
        aresetn   = 1'b1;
        t_addr[0] = 32'h4;
        t_addr[1] = 32'h8;
        we        = 2'b00;
        req       = 2'b11;
        for (int g = 0; g < 4; g++) begin
            wait_ack(20);
            check_val("rr_ack",   ack,   (g % 2 == 0) ? 2'b01 : 2'b10);
            check_val("rr_rdata", rdata, (g % 2 == 0) ? 32'h1111_1111 : 32'h2222_2222);
        end
        req = '0;
        cyc();

        // Write with AW stalled 3 cycles, W accepted in cycle 1
        aw_dly     = 3;
        beats0     = w_beats;
        t_addr[0]  = 32'h8;
        t_wdata[0] = 32'h1234_5678;
        we         = 2'b01;
        req        = 2'b01;
        cyc();
        check_val("aws_c1", {bus.awvalid, bus.wvalid}, 2'b11);
        for (int c = 2; c <= 4; c++) begin
            cyc();
            check_val("aws_c2to4", {bus.awvalid, bus.wvalid, bus.bready}, 3'b100);
        end
        cyc();  // cycle 5
        check_val("aws_c5_wresp", valids(), 5'b00010);
        cyc();  // cycle 6
        check_val("aws_c6_ack",   ack,              2'b01);
        req = '0;
        check_val("aws_wbeats",   w_beats - beats0, 1);
        check_val("aws_mem2",     mem[2],           32'h1234_5678);
        aw_dly = 0;
        cyc();

        // Read with rvalid delayed 5 cycles and SLVERR
        r_dly     = 5;
        rresp_cfg = 2'b10;
        we        = 2'b00;
        req       = 2'b01;
        cyc();
        check_val("rdl_c1_arv", bus.arvalid, 1'b1);
        for (int c = 2; c <= 7; c++) begin
            cyc();
            check_val("rdl_wait", {bus.rready, ack}, 3'b100);
        end
        cyc();  // cycle 8
        check_val("rdl_ack",   ack,   2'b01);
        check_val("rdl_resp",  resp,  2'b10);
        check_val("rdl_rdata", rdata, 32'h1234_5678);
        req       = '0;
        r_dly     = 0;
        rresp_cfg = 2'b00;
        cyc();

        // Reset while waiting for B: abandon, no ack, then requester 0 first
        b_dly      = 3;
        t_addr[1]  = 32'hC;
        t_wdata[1] = 32'hCAFE_F00D;
        we         = 2'b10;
        req        = 2'b10;
        cyc();
        check_val("rsb_c1", {bus.awvalid, bus.wvalid}, 2'b11);
        cyc();
        check_val("rsb_c2_bready", bus.bready, 1'b1);
        aresetn = 1'b0;
        #1;
        check_val("rsb_valids", valids(), 5'b0);
        check_val("rsb_ack",    ack,      2'b00);
        check_val("rsb_resp",   resp,     2'b00);
        check_val("rsb_rdata",  rdata,    32'h0);
        req = '0;
        cyc();
        aresetn = 1'b1;
        b_dly   = 0;
        repeat (4) begin
            cyc();
            check_val("rsb_no_ack", {ack, valids()}, 7'b0);
        end
        t_addr[0] = 32'h4;
        t_addr[1] = 32'h8;
        we        = 2'b00;
        req       = 2'b11;
        wait_ack(20);
        check_val("rsb_next_ack",   ack,   2'b01);
        check_val("rsb_next_rdata", rdata, 32'h1111_1111);
        req = '0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
